mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Line-burst memory controller that sits directly downstream of the data cache and serves its refill and writeback traffic. It accepts one line transaction at a time through a valid/ready handshake, models a fixed first-beat access latency, then streams `LINE_WORDS` 32-bit beats, one per cycle, in or out of an internal word-addressed backing array. It replaces the cache's direct single-word data-memory access with a burst protocol, so that miss penalties are realistic and observable.

## Interface
- `ADDR_WIDTH`, 17: byte-address bits that index the backing array; array depth is 2^(ADDR_WIDTH-2) words.
- `LINE_WORDS`, 4: beats per line; must be a power of two, at least 2.
- `LATENCY`, 3: cycles from request acceptance to the first beat; must be at least 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: the cache presents a line transaction.
- `req_ready` out 1: the controller is idle and accepts a transaction this cycle.
- `req_we` in 1: 1 = line writeback, 0 = line refill.
- `req_addr` in 32: byte address; line base is `req_addr[31:log2(LINE_WORDS)+2]`, requested word is `req_addr[log2(LINE_WORDS)+1:2]`.
- `wdata` in 32: writeback beat data, sampled while `wdata_ready`=1.
- `wdata_ready` out 1: a writeback beat is consumed this cycle.
- `rdata` out 32: refill beat data; 0 when `rdata_valid`=0.
- `rdata_valid` out 1: a refill beat is present this cycle.
- `beat_idx` out log2(LINE_WORDS): word-in-line index of the current beat; 0 outside a burst.
- `done` out 1: high during the last beat of a transaction.

## Operation
- States:
  - IDLE: `req_ready`=1. `req_valid`=1 at a rising edge accepts the transaction. `req_we` and the line base are captured, and the start word is captured (see Configuration). If `LATENCY`=1, go to BURST; otherwise load the latency counter with `LATENCY`-2 and go to WAIT.
  - WAIT: all outputs idle. The counter decrements each cycle. When the counter is 0, go to BURST.
  - BURST: exactly `LINE_WORDS` consecutive beats with no back-pressure. `beat_idx` = (start + n) mod `LINE_WORDS` for beat n. After the last beat, go to IDLE.
- Refill beat: `rdata_valid`=1 and `rdata` = array[{line base, beat_idx}], a combinational read of the array.
- Writeback beat: `wdata_ready`=1. The array word {line base, beat_idx} is written with `wdata` at the edge that ends the beat. Writes are full words only.
- Addressing: only `req_addr[ADDR_WIDTH-1:2]` indexes the array. Higher bits are ignored, so addresses alias modulo 2^ADDR_WIDTH bytes.
- The backing array is not cleared by reset; its contents persist across `rst`.
- `req_valid` asserted outside IDLE is ignored and does not queue. The cache keeps it asserted until accepted.

## Timing
- Reset values while `rst`=1 and in the first cycle after release: state IDLE, `req_ready`=1, `rdata_valid`=0, `wdata_ready`=0, `done`=0, `beat_idx`=0, `rdata`=0.
- Accept edge E0 → first beat occupies the cycle after edge E0+`LATENCY`-1, i.e. `LATENCY` cycles after acceptance → last beat `LATENCY`+`LINE_WORDS`-1 cycles after acceptance.
- `done` coincides with the last `rdata_valid` or `wdata_ready` cycle.
- Back-to-back transactions: `req_ready` returns in the cycle after the last beat, giving a minimum of one idle cycle between bursts.
- Writeback followed by refill of the same line returns the newly written data.
- Reset mid-WAIT or mid-BURST: the transaction is abandoned immediately and asynchronously, and outputs take their reset values. Array words written by beats completed before reset are retained; later beats are never written.

## Configuration
- `MEMCTRL_CWF_EN` (critical word first):
  - Defined: refill bursts start at the requested word of `req_addr` and wrap modulo `LINE_WORDS`. Writeback bursts always start at 0.
  - Undefined: every burst starts at word 0, and the requested-word bits are ignored.

## Test plan
- Reset: hold `rst`=1 mid-stream → `req_ready`=1, `rdata_valid`=0, `wdata_ready`=0, `done`=0, `rdata`=0.
- Writeback then refill (defaults): writeback to 0x0000_0120 with beats 0x11, 0x22, 0x33, 0x44 → `wdata_ready` high 3–6 cycles after acceptance, `done` on the 4th beat. Refill of 0x120 → `rdata` 0x11, 0x22, 0x33, 0x44 with `beat_idx` 0, 1, 2, 3.
- Critical word first: refill of 0x0000_0128 → with `MEMCTRL_CWF_EN`, `beat_idx` 2, 3, 0, 1 and data 0x33, 0x44, 0x11, 0x22; without it, 0–3 in order.
- Reset mid-burst: assert `rst` after beat 1 of a writeback of 0xAA, 0xBB, 0xCC, 0xDD to 0x200 → outputs return to reset values at once. A later refill of 0x200 returns 0xAA, 0xBB at words 0–1 and the prior contents at words 2–3.
- Held request: `req_valid` kept high throughout with `LATENCY`=1 → second acceptance exactly one idle cycle after the first `done`; no duplicate transaction.
- Aliasing: refill of 0x0002_0120 with `ADDR_WIDTH`=17 → same data as 0x0000_0120.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Line-burst memory controller: one line transaction at a time, fixed first-beat latency,
// LINE_WORDS beats in/out of a word-addressed backing array. MEMCTRL_CWF_EN enables critical-word-first refills.
module mem_burst_ctrl #(
    parameter int ADDR_WIDTH = 17,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   wdata,
    output logic                          wdata_ready,
    output logic [31:0]                   rdata,
    output logic                          rdata_valid,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
    output logic                          done
);

    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int WW    = ADDR_WIDTH - 2;
    localparam int BW    = WW - OFF;
    localparam int DEPTH = 1 << WW;
    localparam int CW    = $clog2(LATENCY + 1);
    localparam int LOADV = (LATENCY >= 2) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [OFF-1:0]  beat, beat_next;
    logic [OFF-1:0]  start, start_next;
    logic [BW-1:0]   base, base_next;
    logic            we, we_next;
    logic [OFF-1:0]  req_word;
    logic [OFF-1:0]  cur_idx;
    logic [WW-1:0]   word_addr;
    logic            unused_addr;

    // Backing array is deliberately never reset so contents survive rst.
    logic [31:0] mem [DEPTH];

`ifdef MEMCTRL_CWF_EN
    assign req_word = req_we ? '0 : req_addr[OFF+1:2];
`else
    assign req_word = '0;
`endif

    assign unused_addr = ^{req_addr[31:ADDR_WIDTH], req_addr[OFF+1:0]};
    assign cur_idx     = start + beat;
    assign word_addr   = {base, cur_idx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            beat  <= '0;
            start <= '0;
            base  <= '0;
            we    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            beat  <= beat_next;
            start <= start_next;
            base  <= base_next;
            we    <= we_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        beat_next   = beat;
        start_next  = start;
        base_next   = base;
        we_next     = we;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata       = '0;
        beat_idx    = '0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_next    = req_we;
                    base_next  = req_addr[ADDR_WIDTH-1:OFF+2];
                    start_next = req_word;
                    beat_next  = '0;
                    if (LATENCY == 1) begin
                        state_next = BURST;
                    end else begin
                        cnt_next   = CW'(LOADV);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_next = BURST;
                else           cnt_next   = cnt - 1'b1;
            end
            BURST: begin
                beat_idx    = cur_idx;
                done        = (beat == OFF'(LINE_WORDS - 1));
                wdata_ready = we;
                rdata_valid = !we;
                rdata       = we ? '0 : mem[word_addr];
                beat_next   = beat + 1'b1;
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write is gated by wdata_ready, which drops asynchronously on rst, so abandoned beats never land.
    always_ff @(posedge clk) begin
        if (wdata_ready) mem[word_addr] <= wdata;
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl: directed writeback/refill, CWF, reset mid-burst, aliasing, held request.
module tb_mem_burst_ctrl;

`ifdef MEMCTRL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, wdata, rdata;
    logic        wdata_ready, rdata_valid, done;
    logic [1:0]  beat_idx;

    logic        req_valid2, req_ready2, req_we2;
    logic [31:0] req_addr2, wdata2, rdata2;
    logic        wdata_ready2, rdata_valid2, done2;
    logic [1:0]  beat_idx2;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct {
        bit          we;
        logic [1:0]  idx;
        logic [31:0] data;
        bit          done;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] wb_line [4];

    mem_burst_ctrl #(.ADDR_WIDTH(17), .LINE_WORDS(4), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .wdata(wdata), .wdata_ready(wdata_ready), .rdata(rdata),
        .rdata_valid(rdata_valid), .beat_idx(beat_idx), .done(done));

    mem_burst_ctrl #(.ADDR_WIDTH(17), .LINE_WORDS(4), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .wdata(wdata2), .wdata_ready(wdata_ready2), .rdata(rdata2),
        .rdata_valid(rdata_valid2), .beat_idx(beat_idx2), .done(done2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) wdata = wb_line[beat_idx];

    // Monitor: every output beat is matched against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rdata_valid || wdata_ready) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL beat_unexpected cyc=%0d we=%0b idx=%0d rdata=%h, required no beat", cyc, wdata_ready, beat_idx, rdata);
            end else begin
                e = sb.pop_front();
                if (wdata_ready != e.we || rdata_valid == wdata_ready || beat_idx != e.idx ||
                    done != e.done || cyc != e.cyc || (!e.we && rdata != e.data))
                begin
                    failed++;
                    $display("FAIL beat cyc=%0d wr=%0b rv=%0b idx=%0d done=%0b rdata=%h, required cyc=%0d we=%0b idx=%0d done=%0b data=%h",
                             cyc, wdata_ready, rdata_valid, beat_idx, done, rdata, e.cyc, e.we, e.idx, e.done, e.data);
                end
            end
        end else begin
            tests++;
            if (rdata != 32'h0 || beat_idx != 2'd0 || done) begin
                failed++;
                $display("FAIL idle_out cyc=%0d rdata=%h idx=%0d done=%0b, required 0/0/0", cyc, rdata, beat_idx, done);
            end
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                tests++;
                failed++;
                e = sb.pop_front();
                $display("FAIL beat_missing cyc=%0d, required beat idx=%0d at cyc=%0d", cyc, e.idx, e.cyc);
            end
        end
    end

    task automatic check_idle(input string name);
        tests++;
        if (!(req_ready && !rdata_valid && !wdata_ready && !done && rdata == 32'h0 && beat_idx == 2'd0)) begin
            failed++;
            $display("FAIL %s ready=%0b rv=%0b wr=%0b done=%0b rdata=%h idx=%0d, required 1/0/0/0/0/0",
                     name, req_ready, rdata_valid, wdata_ready, done, rdata, beat_idx);
        end
    endtask

    task automatic issue(input bit we, input logic [31:0] addr, input int nbeats);
        int   c0;
        int   key;
        bit   got;
        exp_t e;
        logic [1:0] start;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL accept_timeout addr=%h ready=%0b, required 1", addr, req_ready);
            return;
        end
        c0    = cyc + 1;
        start = (CWF && !we) ? addr[3:2] : 2'd0;
        for (int k = 0; k < nbeats; k++) begin
            e.we   = we;
            e.idx  = start + 2'(k);
            key    = int'({addr[16:4], e.idx});
            if (we) begin
                model[key] = wb_line[e.idx];
                e.data     = wb_line[e.idx];
            end else begin
                e.data = model.exists(key) ? model[key] : 32'h0;
            end
            e.done = (k == 3);
            e.cyc  = c0 + LAT - 1 + k;
            sb.push_back(e);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        tests++;
        if (sb.size() > 0) begin
            failed++;
            $display("FAIL drain_timeout pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; wdata2 = '0;
        for (int i = 0; i < 4; i++) wb_line[i] = '0;
        repeat (2) @(negedge clk);
        check_idle("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_release");

        // Held request on the LATENCY=1 instance: pattern repeats every 5 cycles.
        req_valid2 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (req_ready2) got = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL held_ready_timeout ready=%0b, required 1", req_ready2);
        end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (req_ready2 != (i % 5 == 0) || rdata_valid2 != (i % 5 != 0) || done2 != (i % 5 == 4)) begin
                failed++;
                $display("FAIL held_req step=%0d ready=%0b rv=%0b done=%0b, required %0b/%0b/%0b",
                         i, req_ready2, rdata_valid2, done2, (i % 5 == 0), (i % 5 != 0), (i % 5 == 4));
            end
            @(negedge clk);
        end
        req_valid2 = 1'b0;

        wb_line[0] = 32'h11; wb_line[1] = 32'h22; wb_line[2] = 32'h33; wb_line[3] = 32'h44;
        issue(1'b1, 32'h0000_0120, 4); drain();
        issue(1'b0, 32'h0000_0120, 4); drain();
        issue(1'b0, 32'h0000_0128, 4); drain();
        issue(1'b0, 32'h0002_0120, 4); drain();

        wb_line[0] = 32'h1000; wb_line[1] = 32'h1001; wb_line[2] = 32'h1002; wb_line[3] = 32'h1003;
        issue(1'b1, 32'h0000_0200, 4); drain();

        issue(1'b0, 32'h0000_0120, 4);
        issue(1'b0, 32'h0000_0200, 4);
        drain();

        wb_line[0] = 32'hAA; wb_line[1] = 32'hBB; wb_line[2] = 32'hCC; wb_line[3] = 32'hDD;
        issue(1'b1, 32'h0000_0200, 2);
        repeat (LAT + 1) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_idle("rst_mid_burst");
        drain();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'h0000_0200, 4); drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
